// File: rtl/up_bus_combiner.sv
// Combines the wack/rack/rdata returns of NUM_SLAVES up-bus slaves into one registered
// response, with per-transaction timeout, stray-ack filtering and error status.
module up_bus_combiner #(
    parameter int          NUM_SLAVES     = 4,
    parameter int          TIMEOUT_ENABLE = 1,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     up_wreq,
    input  logic                     up_rreq,
    input  logic [NUM_SLAVES-1:0]    s_wack,
    input  logic [NUM_SLAVES-1:0]    s_rack,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     up_wack,
    output logic                     up_rack,
    output logic [31:0]              up_rdata,
    input  logic                     up_err_clr,
    output logic [15:0]              up_timeout_cnt,
    output logic                     up_multi_ack,
    output logic                     up_stray_ack
);

    // Handshake: up_rreq/up_wreq are single-cycle request pulses, one outstanding per
    // direction; s_*ack are single-cycle completion pulses; up_*ack pulse once per request.
    localparam logic [0:0]            ST_IDLE    = 1'b0;
    localparam logic [0:0]            ST_WAIT    = 1'b1;
    localparam logic [15:0]           TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_SLAVES-1:0] ONE        = NUM_SLAVES'(1);

    logic [0:0]  rd_state, rd_state_nxt, wr_state, wr_state_nxt;
    logic [15:0] rd_timer, rd_timer_nxt, wr_timer, wr_timer_nxt;
    logic        rd_fwd, rd_to, rd_stray;
    logic        wr_fwd, wr_to, wr_stray;
    logic [31:0] rd_or;
    logic        multi_ev;
    logic [15:0] cnt_base;
    logic [16:0] cnt_sum;

    always_comb begin
        rd_or = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            rd_or = rd_or | (s_rdata[32*i +: 32] & {32{s_rack[i]}});
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_timer_nxt = rd_timer;
        rd_fwd       = 1'b0;
        rd_to        = 1'b0;
        rd_stray     = 1'b0;
        case (rd_state)
            ST_IDLE: begin
                if (|s_rack) begin
                    // same-cycle req+ack completes immediately; ack alone is stray
                    rd_fwd   = up_rreq;
                    rd_stray = ~up_rreq;
                end else if (up_rreq) begin
                    rd_state_nxt = ST_WAIT;
                    rd_timer_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (|s_rack) begin
                    rd_fwd       = 1'b1;
                    rd_state_nxt = ST_IDLE;
                end else if (TIMEOUT_ENABLE != 0) begin
                    if (rd_timer == TIMER_LAST) begin
                        rd_to        = 1'b1;
                        rd_state_nxt = ST_IDLE;
                        rd_timer_nxt = '0;
                    end else begin
                        rd_timer_nxt = rd_timer + 16'd1;
                    end
                end
            end
            default: rd_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_timer_nxt = wr_timer;
        wr_fwd       = 1'b0;
        wr_to        = 1'b0;
        wr_stray     = 1'b0;
        case (wr_state)
            ST_IDLE: begin
                if (|s_wack) begin
                    wr_fwd   = up_wreq;
                    wr_stray = ~up_wreq;
                end else if (up_wreq) begin
                    wr_state_nxt = ST_WAIT;
                    wr_timer_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (|s_wack) begin
                    wr_fwd       = 1'b1;
                    wr_state_nxt = ST_IDLE;
                end else if (TIMEOUT_ENABLE != 0) begin
                    if (wr_timer == TIMER_LAST) begin
                        wr_to        = 1'b1;
                        wr_state_nxt = ST_IDLE;
                        wr_timer_nxt = '0;
                    end else begin
                        wr_timer_nxt = wr_timer + 16'd1;
                    end
                end
            end
            default: wr_state_nxt = ST_IDLE;
        endcase
    end

    // A clear and a new event in the same cycle leave the event visible.
    assign multi_ev = ((s_rack & (s_rack - ONE)) != '0) | ((s_wack & (s_wack - ONE)) != '0);
    assign cnt_base = up_err_clr ? 16'd0 : up_timeout_cnt;
    assign cnt_sum  = {1'b0, cnt_base} + 17'(rd_to) + 17'(wr_to);

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            rd_state       <= ST_IDLE;
            wr_state       <= ST_IDLE;
            rd_timer       <= '0;
            wr_timer       <= '0;
            up_rack        <= 1'b0;
            up_wack        <= 1'b0;
            up_rdata       <= '0;
            up_timeout_cnt <= '0;
            up_multi_ack   <= 1'b0;
            up_stray_ack   <= 1'b0;
        end else begin
            rd_state       <= rd_state_nxt;
            wr_state       <= wr_state_nxt;
            rd_timer       <= rd_timer_nxt;
            wr_timer       <= wr_timer_nxt;
            up_rack        <= rd_fwd | rd_to;
            up_wack        <= wr_fwd | wr_to;
            up_rdata       <= rd_fwd ? rd_or : (rd_to ? TIMEOUT_RDATA : 32'd0);
            up_timeout_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            up_multi_ack   <= (up_multi_ack & ~up_err_clr) | multi_ev;
            up_stray_ack   <= (up_stray_ack & ~up_err_clr) | rd_stray | wr_stray;
        end
    end

endmodule

// File: tb/tb_up_bus_combiner.sv
// Bench for up_bus_combiner: directed scenarios then random traffic, all checked
// against a deadline-based transaction model.
module tb_up_bus_combiner;

    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [31:0] TO_DATA = 32'hDEAD_DEAD;

    logic              up_clk = 1'b0;
    logic              up_rstn = 1'b0;
    logic              up_wreq = 1'b0, up_rreq = 1'b0;
    logic [NS-1:0]     s_wack = '0, s_rack = '0;
    logic [32*NS-1:0]  s_rdata = '0;
    logic              up_wack, up_rack;
    logic [31:0]       up_rdata;
    logic              up_err_clr = 1'b0;
    logic [15:0]       up_timeout_cnt;
    logic              up_multi_ack, up_stray_ack;

    up_bus_combiner #(
        .NUM_SLAVES(NS), .TIMEOUT_ENABLE(1), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(TO_DATA)
    ) dut (
        .up_clk(up_clk), .up_rstn(up_rstn), .up_wreq(up_wreq), .up_rreq(up_rreq),
        .s_wack(s_wack), .s_rack(s_rack), .s_rdata(s_rdata),
        .up_wack(up_wack), .up_rack(up_rack), .up_rdata(up_rdata),
        .up_err_clr(up_err_clr), .up_timeout_cnt(up_timeout_cnt),
        .up_multi_ack(up_multi_ack), .up_stray_ack(up_stray_ack)
    );

    always #5 up_clk = ~up_clk;

    int n_total = 0;
    int n_bad   = 0;

    // transaction model: a channel is either free or owes an answer by a deadline cycle
    int  cyc = 0;
    bit  r_busy, w_busy;
    int  r_deadline, w_deadline;
    int  m_cnt;
    bit  m_multi, m_stray;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        r_busy = 0; w_busy = 0; m_cnt = 0; m_multi = 0; m_stray = 0;
    endtask

    task automatic step(input logic rq, input logic wq, input logic [NS-1:0] ra,
                        input logic [NS-1:0] wa, input logic [32*NS-1:0] rd, input logic clr);
        logic        e_rack, e_wack;
        logic [31:0] e_rdata, acked_or;
        @(negedge up_clk);
        up_rreq = rq; up_wreq = wq; s_rack = ra; s_wack = wa; s_rdata = rd; up_err_clr = clr;
        e_rack = 0; e_wack = 0; e_rdata = 0; acked_or = 0;
        for (int i = 0; i < NS; i++) if (ra[i]) acked_or |= rd[32*i +: 32];
        if (clr) begin m_cnt = 0; m_multi = 0; m_stray = 0; end
        if ($countones(ra) > 1 || $countones(wa) > 1) m_multi = 1;
        if (ra != 0) begin
            if (r_busy || rq) begin e_rack = 1; e_rdata = acked_or; r_busy = 0; end
            else m_stray = 1;
        end else if (r_busy && cyc == r_deadline) begin
            e_rack = 1; e_rdata = TO_DATA; r_busy = 0; m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else if (!r_busy && rq) begin
            r_busy = 1; r_deadline = cyc + TO;
        end
        if (wa != 0) begin
            if (w_busy || wq) begin e_wack = 1; w_busy = 0; end
            else m_stray = 1;
        end else if (w_busy && cyc == w_deadline) begin
            e_wack = 1; w_busy = 0; m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else if (!w_busy && wq) begin
            w_busy = 1; w_deadline = cyc + TO;
        end
        cyc++;
        @(posedge up_clk); #1;
        chk("rack", 32'(up_rack), 32'(e_rack));
        chk("wack", 32'(up_wack), 32'(e_wack));
        chk("rdata", up_rdata, e_rdata);
        chk("to_cnt", 32'(up_timeout_cnt), 32'(m_cnt));
        chk("multi", 32'(up_multi_ack), 32'(m_multi));
        chk("stray", 32'(up_stray_ack), 32'(m_stray));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0);
    endtask

    logic [32*NS-1:0] rd_pat;

    initial begin
        model_reset();
        // reset state
        #12;
        chk("rst_rack", 32'(up_rack), 0);
        chk("rst_wack", 32'(up_wack), 0);
        chk("rst_rdata", up_rdata, 0);
        chk("rst_cnt", 32'(up_timeout_cnt), 0);
        chk("rst_flags", {30'd0, up_multi_ack, up_stray_ack}, 0);
        @(negedge up_clk); up_rstn = 1'b1;

        // read acked by slave 2 one cycle after request
        rd_pat = {32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        step(1, 0, '0, '0, rd_pat, 0);
        chk("rd_early", 32'(up_rack), 0);
        step(0, 0, 4'b0100, '0, rd_pat, 0);
        chk("rd_ack", 32'(up_rack), 1);
        chk("rd_data", up_rdata, 32'h1234_5678);
        idle(1);
        chk("rd_pulse", 32'(up_rack), 0);

        // read timeout, then a late ack
        step(1, 0, '0, '0, '0, 0);
        idle(7);
        chk("to_not_yet", 32'(up_rack), 0);
        idle(1);
        chk("to_rack", 32'(up_rack), 1);
        chk("to_rdata", up_rdata, TO_DATA);
        chk("to_cnt1", 32'(up_timeout_cnt), 1);
        idle(2);
        step(0, 0, 4'b0001, '0, {4{32'hCAFE_F00D}}, 0);
        chk("late_rack", 32'(up_rack), 0);
        chk("late_stray", 32'(up_stray_ack), 1);

        // multi-ack write, then clear
        step(0, 1, '0, '0, '0, 0);
        step(0, 0, '0, 4'b1001, '0, 0);
        chk("multi_wack", 32'(up_wack), 1);
        chk("multi_flag", 32'(up_multi_ack), 1);
        step(0, 0, '0, '0, '0, 1);
        chk("multi_clr", 32'(up_multi_ack), 0);

        // simultaneous read and write, acked together two cycles later
        step(1, 1, '0, '0, '0, 0);
        idle(1);
        step(0, 0, 4'b0010, 4'b0100, {4{32'h0F0F_A5A5}}, 0);
        chk("both_rack", 32'(up_rack), 1);
        chk("both_wack", 32'(up_wack), 1);
        idle(1);

        // preload the counter near saturation, then push it over with write timeouts
        @(negedge up_clk);
        force dut.up_timeout_cnt = 16'hFFFD;
        @(posedge up_clk); #1;
        release dut.up_timeout_cnt;
        cyc++;
        m_cnt = 65533;
        chk("preload", 32'(up_timeout_cnt), 32'hFFFD);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, '0, '0, '0, 0);
            idle(TO);
        end
        chk("sat", 32'(up_timeout_cnt), 32'hFFFF);
        step(0, 1, '0, '0, '0, 0);
        idle(TO - 1);
        step(0, 0, '0, '0, '0, 1);
        chk("clr_vs_to", 32'(up_timeout_cnt), 1);

        // reset in the middle of a read at timer = 4
        step(1, 0, '0, '0, '0, 0);
        idle(4);
        @(negedge up_clk); up_rstn = 1'b0;
        #1;
        chk("mid_rst_out", {up_rack, up_wack, up_multi_ack, up_stray_ack}, 0);
        chk("mid_rst_data", up_rdata, 0);
        chk("mid_rst_cnt", 32'(up_timeout_cnt), 0);
        chk("mid_rst_state", 32'(dut.rd_state), 0);
        @(posedge up_clk); #1;
        @(negedge up_clk); up_rstn = 1'b1;
        model_reset();
        idle(TO + 2);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [NS-1:0] ra, wa;
            for (int i = 0; i < NS; i++) begin
                ra[i] = ($urandom_range(0, 15) == 0);
                wa[i] = ($urandom_range(0, 15) == 0);
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ra, wa,
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
